tp2_multi_cen: RTL and testbench
================================

TP2_MULTI_CEN -- requirements
Module: tp2_multi_cen

Interface
REQ-001 Parameter CH, default 2: number of independent fractional channels.
REQ-002 Parameter W, default 4: binary divider stages per channel (outputs /1, /2, /4 .. /2^(W-1)).
REQ-003 Parameter NW, default 10: width of each channel's n and m ratio terms.
REQ-004 Parameter N_INIT, default {10'd8,10'd1}: packed CH*NW reset n values, channel 0 in the LSBs.
REQ-005 Parameter M_INIT, default {10'd189,10'd7}: packed CH*NW reset m values, channel 0 in the LSBs.
REQ-006 CLK  in  1  sole clock, all logic on rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 PAUSE  in  1  freezes all channel state while high.
REQ-009 WR  in  1  single-cycle ratio write strobe.
REQ-010 WR_CH  in  clog2(CH) (min 1)  target channel of the write.
REQ-011 WR_N  in  NW  new numerator.
REQ-012 WR_M  in  NW  new denominator.
REQ-013 WR_ERR  out  1  one-cycle pulse on a rejected write.
REQ-014 PEND  out  CH  per-channel "ratio write pending" flag.
REQ-015 SYNC  in  1  phase-realign strobe (present only with TP2_CEN_RESYNC_EN).
REQ-016 CEN  out  CH*W  clock-enable pulses, index c*W+k = channel c, stage k.
REQ-017 CENB  out  CH*W  half-period-offset enables, same indexing.

Function
REQ-018 Each channel SHALL hold an NW+1-bit accumulator acc, satisfying acc < m at all times.
REQ-019 Per cycle with PAUSE low: when acc+n >= m, the channel SHALL raise base pulse P and set acc to acc+n-m; otherwise acc SHALL become acc+n.
REQ-020 Averaged over m cycles, the channel SHALL produce exactly n pulses of P; n==m SHALL give P every cycle.
REQ-021 Each channel SHALL hold a W-1-bit divider counter cnt, incremented modulo 2^(W-1) on every P.
REQ-022 CEN[c,0] SHALL equal P; CEN[c,k] for k>=1 SHALL equal P with cnt[k-1:0]==0, sampled before the increment.
REQ-023 CENB[c,k] for k>=1 SHALL equal P with cnt[k-1:0]==2^(k-1).
REQ-024 CENB[c,0] SHALL pulse when acc < m>>1 and acc+n >= m>>1; it MAY coincide with CEN[c,0].
REQ-025 All CEN/CENB outputs SHALL be registered, one cycle after the accumulator compare, and SHALL be single-cycle pulses.
REQ-026 While PAUSE is high: acc, cnt and pending state SHALL hold, and all CEN/CENB outputs SHALL be 0; writes SHALL still be accepted.
REQ-027 A write with WR_M==0, WR_N==0, WR_N>WR_M or WR_CH>=CH SHALL be ignored, and WR_ERR SHALL pulse on the next cycle.
REQ-028 A valid write SHALL store {WR_N,WR_M} as pending for WR_CH and set PEND[WR_CH] on the next cycle.
REQ-029 A second write to a pending channel SHALL overwrite the pending value (last write wins).
REQ-030 On the channel's next P, computed with the old n and m, the pending value SHALL become active and PEND SHALL clear; if the resulting acc >= new m, acc SHALL be cleared to 0.
REQ-031 If a write to a channel and that channel's P occur in the same cycle, the new value SHALL remain pending until the following P.

Reset
REQ-032 RESET SHALL load n and m from N_INIT/M_INIT, clear acc, cnt, PEND, WR_ERR, CEN and CENB, and discard pending writes.
REQ-033 RESET SHALL have priority over WR, SYNC and PAUSE.
REQ-034 The first P after reset release SHALL occur on the first cycle where the accumulated n reaches m, with no spurious pulse.

Configuration
REQ-035 Macro TP2_CEN_RESYNC_EN, when defined, SHALL add the SYNC port.
REQ-036 A SYNC pulse SHALL clear acc and cnt of all channels, suppress outputs that cycle and apply any pending ratios immediately, so that every channel restarts phase-aligned.
REQ-037 When TP2_CEN_RESYNC_EN is undefined, the SYNC port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-038 Defaults, 1890 cycles after reset -> ch0 stage0 gives 270 pulses, stage3 gives 33-34; ch1 stage0 gives 80 pulses.
REQ-039 Write ch0 n=1, m=14 mid-run -> PEND[0] high until the next ch0 P; the subsequent spacing is exactly 14 cycles.
REQ-040 Write n=5, m=3 -> WR_ERR pulses once, the ratio is unchanged and PEND stays 0.
REQ-041 PAUSE high for 100 cycles -> zero pulses; after release, the pulse sequence resumes exactly where it stopped.
REQ-042 ch0 n=m=7 -> CEN[0] high every cycle; CEN[1] alternates; CENB[1] pulses on the cycles between CEN[1] pulses.
REQ-043 With TP2_CEN_RESYNC_EN defined, SYNC while PEND[1] is set -> both channels have acc=0, the new ch1 ratio is active next cycle, and there are no outputs in the SYNC cycle.

Source files
------------

// File: rtl/tp2_multi_cen_if.sv
// tp2_multi_cen_if -- ratio-write bus and clock-enable outputs of tp2_multi_cen.
//
// Parameters mirror the block: CH channels, W divider stages, NW-bit ratio terms.
// Signals:
//   WR      ratio write strobe (single cycle)
//   WR_CH   target channel of the write
//   WR_N    new numerator
//   WR_M    new denominator
//   WR_ERR  one-cycle pulse after a rejected write
//   PEND    per-channel "ratio write pending" flags
//   CEN     clock-enable pulses, index c*W+k = channel c, stage k
//   CENB    half-period-offset enable pulses, same indexing
// Modports: master = write source / enable consumer, slave = tp2_multi_cen.
interface tp2_multi_cen_if #(
  parameter int CH  = 2,
  parameter int W   = 4,
  parameter int NW  = 10,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
);
  logic            WR;
  logic [CHW-1:0]  WR_CH;
  logic [NW-1:0]   WR_N;
  logic [NW-1:0]   WR_M;
  logic            WR_ERR;
  logic [CH-1:0]   PEND;
  logic [CH*W-1:0] CEN;
  logic [CH*W-1:0] CENB;

  modport master (
    output WR, WR_CH, WR_N, WR_M,
    input  WR_ERR, PEND, CEN, CENB
  );

  modport slave (
    input  WR, WR_CH, WR_N, WR_M,
    output WR_ERR, PEND, CEN, CENB
  );
endinterface

// File: rtl/tp2_multi_cen.sv
// tp2_multi_cen -- multi-channel fractional clock-enable generator.
//
// Each channel runs a fractional accumulator producing a base pulse P at an
// average rate of n/m per cycle, followed by a binary divider giving enables
// at /1, /2, /4 .. /2^(W-1) of P, plus half-period-offset companions (CENB).
// Ratio updates are staged as "pending" and take effect on the channel's next
// P so the output never glitches mid-period.
//
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous, active-high; loads N_INIT/M_INIT, clears all state
//   PAUSE  freezes accumulators, dividers and pending state; outputs forced 0
//   SYNC   phase-realign strobe (only with TP2_CEN_RESYNC_EN defined)
//   bus    tp2_multi_cen_if.slave: WR/WR_CH/WR_N/WR_M in, WR_ERR/PEND/CEN/CENB out
//
// Configuration macro: TP2_CEN_RESYNC_EN adds the SYNC port; SYNC clears acc and
// cnt of every channel, applies pending ratios at once and blanks outputs for
// that cycle.
module tp2_multi_cen #(
  parameter int               CH     = 2,
  parameter int               W      = 4,
  parameter int               NW     = 10,
  parameter logic [CH*NW-1:0] N_INIT = {10'd8, 10'd1},
  parameter logic [CH*NW-1:0] M_INIT = {10'd189, 10'd7}
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PAUSE,
`ifdef TP2_CEN_RESYNC_EN
  input  logic SYNC,
`endif
  tp2_multi_cen_if.slave bus
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW  = NW + 1;              // accumulator width
  localparam int SW  = NW + 2;              // acc + n without overflow
  localparam int CW  = (W > 1) ? W - 1 : 1; // divider counter width

  localparam logic [CHW:0] CH_LIM = CH[CHW:0];

  // Registered state
  logic [NW-1:0]   n_q   [CH];
  logic [NW-1:0]   m_q   [CH];
  logic [NW-1:0]   pn_q  [CH];
  logic [NW-1:0]   pm_q  [CH];
  logic [AW-1:0]   acc_q [CH];
  logic [CW-1:0]   cnt_q [CH];
  logic [CH-1:0]   pend_q;
  logic            err_q;
  logic [CH*W-1:0] cen_q;
  logic [CH*W-1:0] cenb_q;

  // Next-state values
  logic [NW-1:0]   n_d   [CH];
  logic [NW-1:0]   m_d   [CH];
  logic [NW-1:0]   pn_d  [CH];
  logic [NW-1:0]   pm_d  [CH];
  logic [AW-1:0]   acc_d [CH];
  logic [CW-1:0]   cnt_d [CH];
  logic [CH-1:0]   pend_d;
  logic [CH*W-1:0] cen_d;
  logic [CH*W-1:0] cenb_d;

  // Per-channel accumulator arithmetic
  logic [SW-1:0]   sum_w  [CH];
  logic [SW-1:0]   nxt_w  [CH];
  logic [SW-1:0]   m_w    [CH];
  logic [SW-1:0]   half_w [CH];
  logic [CH-1:0]   p_w;

  logic            wr_ok;
  logic            sync_act;

`ifdef TP2_CEN_RESYNC_EN
  assign sync_act = SYNC;
`else
  assign sync_act = 1'b0;
`endif

  assign wr_ok = bus.WR && (bus.WR_N != '0) && (bus.WR_M != '0) &&
                 (bus.WR_N <= bus.WR_M) && ({1'b0, bus.WR_CH} < CH_LIM);

  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      sum_w[c]  = {1'b0, acc_q[c]} + SW'(n_q[c]);
      m_w[c]    = SW'(m_q[c]);
      half_w[c] = SW'(m_q[c] >> 1);
      p_w[c]    = (sum_w[c] >= m_w[c]);
      nxt_w[c]  = p_w[c] ? (sum_w[c] - m_w[c]) : sum_w[c];
    end
  end

  always_comb begin
    cen_d  = '0;
    cenb_d = '0;
    pend_d = pend_q;
    for (int unsigned c = 0; c < CH; c++) begin
      n_d[c]   = n_q[c];
      m_d[c]   = m_q[c];
      pn_d[c]  = pn_q[c];
      pm_d[c]  = pm_q[c];
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
    end

    for (int unsigned c = 0; c < CH; c++) begin
      if (sync_act) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
        if (pend_q[c]) begin
          n_d[c]    = pn_q[c];
          m_d[c]    = pm_q[c];
          pend_d[c] = 1'b0;
        end
      end else if (!PAUSE) begin
        cen_d[c*W]  = p_w[c];
        cenb_d[c*W] = ({1'b0, acc_q[c]} < half_w[c]) && (sum_w[c] >= half_w[c]);
        // Stage k fires on P when the low k counter bits are 0 (CEN) or at the
        // midpoint 2^(k-1) (CENB); cnt is observed before its increment.
        for (int unsigned k = 1; k < W; k++) begin
          cen_d[c*W+k]  = p_w[c] && ((cnt_q[c] & CW'((1 << k) - 1)) == '0);
          cenb_d[c*W+k] = p_w[c] && ((cnt_q[c] & CW'((1 << k) - 1)) == CW'(1 << (k - 1)));
        end
        acc_d[c] = AW'(nxt_w[c]);
        if (p_w[c]) begin
          cnt_d[c] = cnt_q[c] + CW'(1);
          // Pending ratio takes over on P; the residue from the old ratio is
          // kept unless it would violate acc < m under the new denominator.
          if (pend_q[c]) begin
            n_d[c]    = pn_q[c];
            m_d[c]    = pm_q[c];
            pend_d[c] = 1'b0;
            if (nxt_w[c] >= SW'(pm_q[c])) acc_d[c] = '0;
          end
        end
      end

      // A write landing in the same cycle as P (or SYNC) is staged after the
      // old pending value was consumed, so it waits for the following P.
      if (wr_ok && (bus.WR_CH == CHW'(c))) begin
        pend_d[c] = 1'b1;
        pn_d[c]   = bus.WR_N;
        pm_d[c]   = bus.WR_M;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned c = 0; c < CH; c++) begin
        n_q[c]   <= N_INIT[c*NW +: NW];
        m_q[c]   <= M_INIT[c*NW +: NW];
        pn_q[c]  <= '0;
        pm_q[c]  <= '0;
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      pend_q <= '0;
      err_q  <= 1'b0;
      cen_q  <= '0;
      cenb_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        n_q[c]   <= n_d[c];
        m_q[c]   <= m_d[c];
        pn_q[c]  <= pn_d[c];
        pm_q[c]  <= pm_d[c];
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      pend_q <= pend_d;
      err_q  <= bus.WR && !wr_ok;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
    end
  end

  assign bus.WR_ERR = err_q;
  assign bus.PEND   = pend_q;
  assign bus.CEN    = cen_q;
  assign bus.CENB   = cenb_q;

endmodule

// File: tb/tb_tp2_multi_cen.sv
// tb_tp2_multi_cen -- randomized self-checking bench for tp2_multi_cen with
// default parameters (CH=2, W=4, NW=10). A cycle-level reference model tracks
// each channel's fractional phase and an unbounded pulse count; stage enables
// are derived from that count with modulo arithmetic.
module tb_tp2_multi_cen;
  localparam int CH = 2;
  localparam int W  = 4;
  localparam int NW = 10;

  logic clk = 1'b0;
  logic rst;
  logic pause;
  logic sync;

  always #5 clk = ~clk;

  tp2_multi_cen_if #(.CH(CH), .W(W), .NW(NW)) bus ();

  tp2_multi_cen #(.CH(CH), .W(W), .NW(NW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .PAUSE (pause),
`ifdef TP2_CEN_RESYNC_EN
    .SYNC  (sync),
`endif
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Reference model state
  int mn[CH], mm[CH], macc[CH], mpulses[CH], mpn[CH], mpm[CH];
  bit mpend[CH];
  logic [CH*W-1:0] ecen, ecenb;
  logic            eerr;
  int              dcount[CH*W];   // DUT CEN pulses per output bit

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit pa, input bit w, input int ch,
                            input int wn, input int wm, input bit s);
    int  sum, half;
    bit  p, valid;
    ecen  = '0;
    ecenb = '0;
    if (r) begin
      mn[0] = 1; mm[0] = 7;
      mn[1] = 8; mm[1] = 189;
      for (int c = 0; c < CH; c++) begin
        macc[c] = 0; mpulses[c] = 0; mpend[c] = 0;
      end
      eerr = 1'b0;
    end else begin
      valid = (wn != 0) && (wm != 0) && (wn <= wm) && (ch < CH);
      eerr  = w && !valid;
      for (int c = 0; c < CH; c++) begin
        if (s) begin
          macc[c] = 0;
          mpulses[c] = 0;
          if (mpend[c]) begin
            mn[c] = mpn[c]; mm[c] = mpm[c]; mpend[c] = 0;
          end
        end else if (!pa) begin
          sum  = macc[c] + mn[c];
          p    = (sum >= mm[c]);
          half = mm[c] / 2;
          ecen[c*W]  = p;
          ecenb[c*W] = (macc[c] < half) && (sum >= half);
          for (int k = 1; k < W; k++) begin
            ecen[c*W+k]  = p && ((mpulses[c] % (1 << k)) == 0);
            ecenb[c*W+k] = p && ((mpulses[c] % (1 << k)) == (1 << (k - 1)));
          end
          macc[c] = p ? sum - mm[c] : sum;
          if (p) begin
            mpulses[c]++;
            if (mpend[c]) begin
              mn[c] = mpn[c]; mm[c] = mpm[c]; mpend[c] = 0;
              if (macc[c] >= mm[c]) macc[c] = 0;
            end
          end
        end
      end
      if (w && valid) begin
        mpend[ch] = 1; mpn[ch] = wn; mpm[ch] = wm;
      end
    end
  endtask

  // One clock: drive inputs, clock edge, advance model, compare after the edge.
  task automatic step(input bit r, input bit pa, input bit w, input int ch,
                      input int wn, input int wm, input bit s);
    logic [CH-1:0] epend;
    rst       = r;
    pause     = pa;
    sync      = s;
    bus.WR    = w;
    bus.WR_CH = 1'(ch);
    bus.WR_N  = NW'(wn);
    bus.WR_M  = NW'(wm);
    @(posedge clk);
    model_step(r, pa, w, ch, wn, wm, s);
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) epend[c] = mpend[c];
    chk("cen",  64'(bus.CEN),    64'(ecen));
    chk("cenb", 64'(bus.CENB),   64'(ecenb));
    chk("err",  64'(bus.WR_ERR), 64'(eerr));
    chk("pend", 64'(bus.PEND),   64'(epend));
    for (int i = 0; i < CH*W; i++) if (bus.CEN[i]) dcount[i]++;
    rst = 1'b0; pause = 1'b0; sync = 1'b0; bus.WR = 1'b0;
  endtask

  task automatic idle(input int ncyc);
    for (int i = 0; i < ncyc; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < CH*W; i++) dcount[i] = 0;
  endtask

  initial begin
    int t[3];
    int np, tot, guard, wn, wm;
    bit prev1;

    rst = 1'b1; pause = 1'b0; sync = 1'b0;
    bus.WR = 1'b0; bus.WR_CH = '0; bus.WR_N = '0; bus.WR_M = '0;

    // Reset, including reset overriding simultaneous write/pause
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 3, 9, 1);
    chk("rst_cen", 64'(bus.CEN), 64'd0);
    chk("rst_pend", 64'(bus.PEND), 64'd0);

    // Default ratios over 1890 cycles
    clr_counts();
    idle(1890);
    chk("def_c0s0", 64'(dcount[0]), 64'd270);
    chk("def_c0s3", 64'((dcount[3] == 33) || (dcount[3] == 34)), 64'd1);
    chk("def_c1s0", 64'(dcount[W]), 64'd80);

    // Pause: no pulses, resume continuity checked by the model
    clr_counts();
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0, 0, 0, 0);
    tot = 0;
    for (int i = 0; i < CH*W; i++) tot += dcount[i];
    chk("pause_zero", 64'(tot), 64'd0);
    idle(30);

    // Rejected write n > m
    step(0, 0, 1, 0, 5, 3, 0);
    chk("bad_err", 64'(bus.WR_ERR), 64'd1);
    chk("bad_pend", 64'(bus.PEND[0]), 64'd0);
    idle(10);

    // Ch0 -> 1/14: pending until next P, then 14-cycle spacing
    step(0, 0, 1, 0, 1, 14, 0);
    chk("r14_pend", 64'(bus.PEND[0]), 64'd1);
    np = 0; guard = 0;
    while (np < 3 && guard < 200) begin
      step(0, 0, 0, 0, 0, 0, 0);
      guard++;
      if (bus.CEN[0]) begin
        if (np == 0) chk("r14_pclr", 64'(bus.PEND[0]), 64'd0);
        t[np] = cyc; np++;
      end
    end
    chk("r14_found", 64'(np), 64'd3);
    if (np == 3) begin
      chk("r14_gap1", 64'(t[1] - t[0]), 64'd14);
      chk("r14_gap2", 64'(t[2] - t[1]), 64'd14);
    end

    // Ch0 -> 7/7: every-cycle base, /2 alternates, CENB[1] fills the gaps
    step(0, 0, 1, 0, 7, 7, 0);
    guard = 0;
    while (bus.PEND[0] && guard < 50) begin
      step(0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("r77_applied", 64'(bus.PEND[0]), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    prev1 = bus.CEN[1];
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("r77_c0", 64'(bus.CEN[0]), 64'd1);
      chk("r77_c1alt", 64'(bus.CEN[1]), 64'(!prev1));
      chk("r77_b1", 64'(bus.CENB[1]), 64'(!bus.CEN[1]));
      prev1 = bus.CEN[1];
    end

`ifdef TP2_CEN_RESYNC_EN
    // SYNC while ch1 pending: outputs blanked, ratio applied at once
    step(0, 0, 1, 1, 3, 5, 0);
    chk("sync_pre", 64'(bus.PEND[1]), 64'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("sync_cen", 64'(bus.CEN | bus.CENB), 64'd0);
    chk("sync_pend", 64'(bus.PEND), 64'd0);
    idle(20);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      wm = $urandom_range(0, 40);
      wn = $urandom_range(0, wm + 3);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0), $urandom_range(0, CH - 1), wn, wm,
`ifdef TP2_CEN_RESYNC_EN
           ($urandom_range(0, 49) == 0)
`else
           1'b0
`endif
          );
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
